ex_flag_stage: RTL and testbench
================================

# ex_flag_stage

Execute-to-memory boundary stage directly downstream of the 16-bit saturating ALU. It registers the ALU result into the EX/MEM pipeline register. It maintains the Z/V/N condition-flag register according to per-opcode update rules. It evaluates the 3-bit branch condition code for a branch in flight against those flags. Stall and flush come from the hazard unit; results feed the memory stage and writeback.

## Interface
Parameters:
- DW, 16, datapath width (ALU result width)
- RW, 4, destination register index width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX slot holds a live instruction
- ex_opcode  in  4  opcode of EX instruction (same encoding as ALU alu_code)
- alu_result  in  DW  ALU output (already saturated for ADD/SUB)
- alu_zero  in  1  ALU zero flag
- alu_ovf  in  1  ALU overflow flag
- ex_dst  in  RW  destination register index
- ex_wr_en  in  1  EX instruction writes a register
- stall  in  1  hold EX/MEM register and flags
- flush  in  1  squash EX instruction
- br_valid  in  1  branch awaiting condition evaluation
- br_ccc  in  3  branch condition code
- br_taken  out  1  condition true (combinational)
- br_wait  out  1  branch must retry next cycle (combinational)
- mem_valid  out  1  EX/MEM slot valid
- mem_opcode  out  4  registered opcode
- mem_result  out  DW  registered ALU result
- mem_dst  out  RW  registered destination
- mem_wr_en  out  1  registered write enable, forced 0 when mem_valid=0
- flag_z, flag_v, flag_n  out  1 each  architectural flags

## Operation
- Advance condition: adv = ~stall & ~flush.
- Qualifying op: q = ex_valid & adv.
- Flag update, only when q:
  - ADD 0000, SUB 0001: Z←alu_zero, V←alu_ovf, N←alu_result[DW-1].
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: Z←alu_zero; V and N hold.
  - All other opcodes: no flag change.
- Pipeline register:
  - flush=1: mem_valid←0 and mem_wr_en←0 at the next edge. Flush overrides stall.
  - stall=1 with flush=0: every mem_* output holds.
  - Otherwise: mem_* ← ex_*, and mem_wr_en←ex_wr_en&ex_valid.
- Branch conditions, evaluated on flag set F:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z&~N
  - 011 LT: N
  - 100 GE: Z|(~Z&~N)
  - 101 LE: N|Z
  - 110 OVF: V
  - 111 always: 1
- br_taken=0 whenever br_valid=0 or br_wait=1.
- Reset: all flags 0; all mem_* outputs 0.
- Reset is asynchronous. Asserting it mid-stall or mid-branch clears state immediately. Deasserting it takes effect at the next edge.

## Timing
- EX→MEM latency: 1 cycle.
- Flag write visible on flag_* outputs the cycle after the qualifying EX cycle.
- br_taken and br_wait are combinational from the current cycle's inputs and flags. They carry no registered delay.
- Back-to-back flag-setting ops: each updates flags on its own edge. The last one wins.
- Stall asserted for N cycles: flags and mem_* frozen for N edges.

## Configuration
- FLAG_BYPASS_EN defined:
  - F = next-state flags, i.e. the value the flags will take at the coming edge, including a qualifying op in EX this cycle.
  - br_wait tied to 0.
- FLAG_BYPASS_EN undefined:
  - F = registered flags only.
  - br_wait = br_valid & ex_valid & ~flush & (ex_opcode is a flag-setting opcode).
  - Upstream re-presents the branch the following cycle.

## Test plan
- Reset with rst_n=0 mid-run → all flags and mem_* immediately 0. First instruction after release registers on the next edge.
- ADD, alu_result=16'h8000, alu_ovf=1, alu_zero=0, then br_ccc=110 → flags N=1, V=1, Z=0. OVF branch taken.
- XOR with alu_zero=1 following the ADD above → Z=1, N=1 and V=1 held. LE (101) taken, GT (010) not taken.
- stall=1 for 3 cycles during SUB → mem_result and flags unchanged for 3 edges. SUB commits on the edge after stall drops.
- stall=1 and flush=1 together on an ADD → mem_valid=0, mem_wr_en=0, flags unchanged.
- Same-cycle SUB producing Z=1 and branch EQ (001):
  - With FLAG_BYPASS_EN: br_taken=1, br_wait=0.
  - Without: br_wait=1, br_taken=0. On the retry cycle, br_taken=1.

Source files
------------

// File: rtl/ex_flag_stage_if.sv
// EX/MEM boundary bundle: EX-side inputs, hazard controls, branch query and MEM-side results.
// The master drives the EX side; the slave (the stage) drives MEM outputs and branch status.
interface ex_flag_stage_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 4
);
    logic          ex_valid;
    logic [3:0]    ex_opcode;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          alu_ovf;
    logic [RW-1:0] ex_dst;
    logic          ex_wr_en;
    logic          stall;
    logic          flush;
    logic          br_valid;
    logic [2:0]    br_ccc;
    logic          br_taken;
    logic          br_wait;
    logic          mem_valid;
    logic [3:0]    mem_opcode;
    logic [DW-1:0] mem_result;
    logic [RW-1:0] mem_dst;
    logic          mem_wr_en;
    logic          flag_z;
    logic          flag_v;
    logic          flag_n;

    modport master (
        output ex_valid, ex_opcode, alu_result, alu_zero, alu_ovf, ex_dst, ex_wr_en,
        output stall, flush, br_valid, br_ccc,
        input  br_taken, br_wait, mem_valid, mem_opcode, mem_result, mem_dst, mem_wr_en,
        input  flag_z, flag_v, flag_n
    );

    modport slave (
        input  ex_valid, ex_opcode, alu_result, alu_zero, alu_ovf, ex_dst, ex_wr_en,
        input  stall, flush, br_valid, br_ccc,
        output br_taken, br_wait, mem_valid, mem_opcode, mem_result, mem_dst, mem_wr_en,
        output flag_z, flag_v, flag_n
    );
endinterface

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register with Z/V/N flag register and branch condition evaluation.
// Optional macro FLAG_BYPASS_EN: branches see next-state flags instead of waiting a cycle.
module ex_flag_stage #(
    parameter int unsigned DW = 16,
    parameter int unsigned RW = 4
) (
    input logic           clk,
    input logic           rst_n,
    ex_flag_stage_if.slave bus
);
    logic          w_adv;
    logic          w_q;
    logic          w_set_all;
    logic          w_set_z;
    logic          w_z_d;
    logic          w_v_d;
    logic          w_n_d;
    logic          w_f_z;
    logic          w_f_v;
    logic          w_f_n;
    logic          w_cond;
    logic          w_wait;

    logic          r_z;
    logic          r_v;
    logic          r_n;
    logic          r_mem_valid;
    logic [3:0]    r_mem_opcode;
    logic [DW-1:0] r_mem_result;
    logic [RW-1:0] r_mem_dst;
    logic          r_mem_wr_en;

    function automatic logic cond_eval(input logic [2:0] ccc, input logic z, input logic v,
                                       input logic n);
        logic c;
        c = 1'b0;
        case (ccc)
            3'b000:  c = ~z;
            3'b001:  c = z;
            3'b010:  c = ~z & ~n;
            3'b011:  c = n;
            3'b100:  c = z | (~z & ~n);
            3'b101:  c = n | z;
            3'b110:  c = v;
            default: c = 1'b1;
        endcase
        return c;
    endfunction

    assign w_adv     = ~bus.stall & ~bus.flush;
    assign w_q       = bus.ex_valid & w_adv;
    assign w_set_all = (bus.ex_opcode == 4'b0000) | (bus.ex_opcode == 4'b0001);
    assign w_set_z   = w_set_all | (bus.ex_opcode == 4'b0010) | (bus.ex_opcode == 4'b0100) |
                       (bus.ex_opcode == 4'b0101) | (bus.ex_opcode == 4'b0110);

    always_comb begin
        w_z_d = r_z;
        w_v_d = r_v;
        w_n_d = r_n;
        if (w_q && w_set_z) begin
            w_z_d = bus.alu_zero;
        end
        if (w_q && w_set_all) begin
            w_v_d = bus.alu_ovf;
            w_n_d = bus.alu_result[DW-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z <= 1'b0;
            r_v <= 1'b0;
            r_n <= 1'b0;
        end else begin
            r_z <= w_z_d;
            r_v <= w_v_d;
            r_n <= w_n_d;
        end
    end

    // Flush only kills valid/wr_en; the payload fields are don't-care while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid  <= 1'b0;
            r_mem_opcode <= '0;
            r_mem_result <= '0;
            r_mem_dst    <= '0;
            r_mem_wr_en  <= 1'b0;
        end else if (bus.flush) begin
            r_mem_valid <= 1'b0;
            r_mem_wr_en <= 1'b0;
        end else if (!bus.stall) begin
            r_mem_valid  <= bus.ex_valid;
            r_mem_opcode <= bus.ex_opcode;
            r_mem_result <= bus.alu_result;
            r_mem_dst    <= bus.ex_dst;
            r_mem_wr_en  <= bus.ex_wr_en & bus.ex_valid;
        end
    end

`ifdef FLAG_BYPASS_EN
    assign w_f_z  = w_z_d;
    assign w_f_v  = w_v_d;
    assign w_f_n  = w_n_d;
    assign w_wait = 1'b0;
`else
    assign w_f_z  = r_z;
    assign w_f_v  = r_v;
    assign w_f_n  = r_n;
    assign w_wait = bus.br_valid & bus.ex_valid & ~bus.flush & w_set_z;
`endif

    assign w_cond         = cond_eval(bus.br_ccc, w_f_z, w_f_v, w_f_n);
    assign bus.br_wait    = w_wait;
    assign bus.br_taken   = bus.br_valid & ~w_wait & w_cond;
    assign bus.mem_valid  = r_mem_valid;
    assign bus.mem_opcode = r_mem_opcode;
    assign bus.mem_result = r_mem_result;
    assign bus.mem_dst    = r_mem_dst;
    assign bus.mem_wr_en  = r_mem_wr_en;
    assign bus.flag_z     = r_z;
    assign bus.flag_v     = r_v;
    assign bus.flag_n     = r_n;
endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed bench for ex_flag_stage: flags, pipeline register, stall/flush, branches, reset.
module tb_ex_flag_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ex_flag_stage_if #(.DW(16), .RW(4)) bus ();

    ex_flag_stage #(.DW(16), .RW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic v, input logic [3:0] op, input logic [15:0] res,
                      input logic z, input logic o, input logic [3:0] dst, input logic wr);
        bus.ex_valid   = v;
        bus.ex_opcode  = op;
        bus.alu_result = res;
        bus.alu_zero   = z;
        bus.alu_ovf    = o;
        bus.ex_dst     = dst;
        bus.ex_wr_en   = wr;
    endtask

    task automatic check_flags(input string tag, input logic z, input logic v, input logic n);
        check({tag, "_z"}, {31'd0, bus.flag_z}, {31'd0, z});
        check({tag, "_v"}, {31'd0, bus.flag_v}, {31'd0, v});
        check({tag, "_n"}, {31'd0, bus.flag_n}, {31'd0, n});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        ex(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0);
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.br_valid = 1'b0;
        bus.br_ccc   = 3'b000;
        step();
        step();
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        check("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("rst_result", {16'd0, bus.mem_result}, 32'd0);
        rst_n = 1'b1;
        step();

        // ADD saturated negative with overflow
        ex(1'b1, 4'h0, 16'h8000, 1'b0, 1'b1, 4'h3, 1'b1);
        step();
        check_flags("add", 1'b0, 1'b1, 1'b1);
        check("add_valid", {31'd0, bus.mem_valid}, 32'd1);
        check("add_result", {16'd0, bus.mem_result}, 32'h8000);
        check("add_dst", {28'd0, bus.mem_dst}, 32'h3);
        check("add_wr", {31'd0, bus.mem_wr_en}, 32'd1);

        ex(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0);
        bus.br_valid = 1'b1;
        bus.br_ccc   = 3'b110;
        #1;
        check("ovf_taken", {31'd0, bus.br_taken}, 32'd1);
        check("ovf_wait", {31'd0, bus.br_wait}, 32'd0);

        // XOR sets only Z
        bus.br_valid = 1'b0;
        ex(1'b1, 4'h2, 16'h0000, 1'b1, 1'b0, 4'h4, 1'b1);
        step();
        check_flags("xor", 1'b1, 1'b1, 1'b1);
        check("xor_op", {28'd0, bus.mem_opcode}, 32'h2);
        ex(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0);
        bus.br_valid = 1'b1;
        bus.br_ccc   = 3'b101;
        #1;
        check("le_taken", {31'd0, bus.br_taken}, 32'd1);
        bus.br_ccc = 3'b010;
        #1;
        check("gt_taken", {31'd0, bus.br_taken}, 32'd0);
        bus.br_valid = 1'b0;

        // SUB held by a 3-cycle stall
        ex(1'b1, 4'h1, 16'h1234, 1'b0, 1'b0, 4'h5, 1'b1);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_result", {16'd0, bus.mem_result}, 32'h0000);
            check("stall_op", {28'd0, bus.mem_opcode}, 32'h2);
            check_flags("stall", 1'b1, 1'b1, 1'b1);
        end
        bus.stall = 1'b0;
        step();
        check("sub_result", {16'd0, bus.mem_result}, 32'h1234);
        check("sub_dst", {28'd0, bus.mem_dst}, 32'h5);
        check_flags("sub", 1'b0, 1'b0, 1'b0);

        // Flush overrides stall
        ex(1'b1, 4'h0, 16'h0000, 1'b1, 1'b0, 4'h6, 1'b1);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step();
        check("flush_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("flush_wr", {31'd0, bus.mem_wr_en}, 32'd0);
        check_flags("flush", 1'b0, 1'b0, 1'b0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;

        // Same-cycle SUB producing Z with EQ branch
        ex(1'b1, 4'h1, 16'h0000, 1'b1, 1'b0, 4'h1, 1'b1);
        bus.br_valid = 1'b1;
        bus.br_ccc   = 3'b001;
        #1;
`ifdef FLAG_BYPASS_EN
        check("eq_same_taken", {31'd0, bus.br_taken}, 32'd1);
        check("eq_same_wait", {31'd0, bus.br_wait}, 32'd0);
`else
        check("eq_same_taken", {31'd0, bus.br_taken}, 32'd0);
        check("eq_same_wait", {31'd0, bus.br_wait}, 32'd1);
`endif
        step();
        ex(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0);
        #1;
        check("eq_retry_taken", {31'd0, bus.br_taken}, 32'd1);
        check("eq_retry_wait", {31'd0, bus.br_wait}, 32'd0);

        // Non-flag opcode: no wait, no flag change
        ex(1'b1, 4'h3, 16'h0001, 1'b0, 1'b1, 4'h2, 1'b1);
        bus.br_ccc = 3'b000;
        #1;
        check("op3_wait", {31'd0, bus.br_wait}, 32'd0);
        check("ne_taken", {31'd0, bus.br_taken}, 32'd0);
        step();
        check_flags("op3", 1'b1, 1'b0, 1'b0);
        check("op3_op", {28'd0, bus.mem_opcode}, 32'h3);

        // Invalid EX slot never writes
        ex(1'b0, 4'h0, 16'h0002, 1'b0, 1'b0, 4'h2, 1'b1);
        bus.br_ccc = 3'b111;
        #1;
        check("always_taken", {31'd0, bus.br_taken}, 32'd1);
        bus.br_valid = 1'b0;
        #1;
        check("nobr_taken", {31'd0, bus.br_taken}, 32'd0);
        step();
        check("inv_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("inv_wr", {31'd0, bus.mem_wr_en}, 32'd0);

        // Asynchronous reset mid-stall and mid-branch
        ex(1'b1, 4'h0, 16'h8001, 1'b0, 1'b1, 4'h9, 1'b1);
        step();
        check_flags("pre_rst", 1'b0, 1'b1, 1'b1);
        bus.stall    = 1'b1;
        bus.br_valid = 1'b1;
        bus.br_ccc   = 3'b110;
        #2;
        rst_n = 1'b0;
        #1;
        check_flags("async_rst", 1'b0, 1'b0, 1'b0);
        check("async_valid", {31'd0, bus.mem_valid}, 32'd0);
        check("async_result", {16'd0, bus.mem_result}, 32'd0);
        check("async_br", {31'd0, bus.br_taken}, 32'd0);
        rst_n = 1'b1;
        bus.stall    = 1'b0;
        bus.br_valid = 1'b0;
        ex(1'b1, 4'h1, 16'h0000, 1'b1, 1'b0, 4'h7, 1'b1);
        #1;
        check("rel_pre_valid", {31'd0, bus.mem_valid}, 32'd0);
        step();
        check("rel_valid", {31'd0, bus.mem_valid}, 32'd1);
        check("rel_dst", {28'd0, bus.mem_dst}, 32'h7);
        check_flags("rel", 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
